gpio_in_filter: RTL and testbench



---
 rtl/gpio_in_filter_if.sv | 33 +++
 rtl/gpio_in_filter.sv | 95 +++++++++
 tb/tb_gpio_in_filter.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_in_filter_if.sv
// Pin-bank bus for gpio_in_filter: raw pads and enables in, conditioned level and edge pulses out.
// Optional glitch-counter signals exist only when GPIO_IN_FILTER_GLITCH_CNT_EN is defined.
interface gpio_in_filter_if #(
    parameter int Width = 32
);
    logic [Width-1:0] cio_gpio_i;
    logic [Width-1:0] filter_en_i;
    logic [Width-1:0] data_in_o;
    logic [Width-1:0] rise_o;
    logic [Width-1:0] fall_o;
`ifdef GPIO_IN_FILTER_GLITCH_CNT_EN
    logic             glitch_clr_i;
    logic [15:0]      glitch_cnt_o;

    modport master (
        output cio_gpio_i, filter_en_i, glitch_clr_i,
        input  data_in_o, rise_o, fall_o, glitch_cnt_o
    );
    modport slave (
        input  cio_gpio_i, filter_en_i, glitch_clr_i,
        output data_in_o, rise_o, fall_o, glitch_cnt_o
    );
`else
    modport master (
        output cio_gpio_i, filter_en_i,
        input  data_in_o, rise_o, fall_o
    );
    modport slave (
        input  cio_gpio_i, filter_en_i,
        output data_in_o, rise_o, fall_o
    );
`endif
endinterface

// File: rtl/gpio_in_filter.sv
// Vectorised GPIO input conditioner: synchroniser, optional stability debounce, rise/fall pulses; optional glitch counter under GPIO_IN_FILTER_GLITCH_CNT_EN.
// Latency SyncStages+1 clocks unfiltered, SyncStages+Cycles+2 filtered; no backpressure, every cycle is a sample.
module gpio_in_filter #(
    parameter int Width      = 32,
    parameter int Cycles     = 16,
    parameter int SyncStages = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    gpio_in_filter_if.slave  io
);
    localparam int            CntW   = $clog2(Cycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(Cycles);

    logic [Width-1:0] sync_chain [SyncStages];
    logic [Width-1:0] sync_q;
    logic [Width-1:0] diff_q;
    logic [CntW-1:0]  cnt_q [Width];
    logic [Width-1:0] cnt_done;
    logic [Width-1:0] filt_d;
    logic [Width-1:0] filt_q;
    logic [Width-1:0] prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SyncStages; s++) sync_chain[s] <= '0;
        end else begin
            sync_chain[0] <= io.cio_gpio_i;
            for (int s = 1; s < SyncStages; s++) sync_chain[s] <= sync_chain[s-1];
        end
    end

    assign sync_q = sync_chain[SyncStages-1];

    always_comb begin
        cnt_done = '0;
        for (int i = 0; i < Width; i++) cnt_done[i] = (cnt_q[i] == CntMax);
    end

    // Tracker runs even on unfiltered lanes so a later enable sees a qualified counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            diff_q <= '0;
            for (int i = 0; i < Width; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < Width; i++) begin
                if (sync_q[i] != diff_q[i]) begin
                    diff_q[i] <= sync_q[i];
                    cnt_q[i]  <= '0;
                end else if (!cnt_done[i]) begin
                    cnt_q[i]  <= cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    assign filt_d = (io.filter_en_i  & cnt_done  & diff_q)
                  | (io.filter_en_i  & ~cnt_done & filt_q)
                  | (~io.filter_en_i & sync_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q <= '0;
            prev_q <= '0;
        end else begin
            filt_q <= filt_d;
            prev_q <= filt_q;
        end
    end

    assign io.data_in_o = filt_q;
    assign io.rise_o    = filt_q & ~prev_q;
    assign io.fall_o    = ~filt_q & prev_q;

`ifdef GPIO_IN_FILTER_GLITCH_CNT_EN
    logic        glitch_hit;
    logic [15:0] glitch_cnt_q;

    // A change seen before the counter qualifies is a pulse the filter will swallow.
    assign glitch_hit = |(io.filter_en_i & (sync_q ^ diff_q) & ~cnt_done);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            glitch_cnt_q <= '0;
        end else if (io.glitch_clr_i) begin
            glitch_cnt_q <= '0;
        end else if (glitch_hit && (glitch_cnt_q != 16'hFFFF)) begin
            glitch_cnt_q <= glitch_cnt_q + 16'd1;
        end
    end

    assign io.glitch_cnt_o = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// Self-checking bench for gpio_in_filter: edge events scored through an expected/observed queue pair.
module tb_gpio_in_filter;
    localparam int W   = 32;
    localparam int CYC = 16;
    localparam int SS  = 2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    gpio_in_filter_if #(.Width(W)) bus ();

    gpio_in_filter #(.Width(W), .Cycles(CYC), .SyncStages(SS)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .io     (bus)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  lane;
        logic        rise;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < W; i++) begin
                if (bus.rise_o[i]) obs_q.push_back('{32'(cyc), 8'(i), 1'b1});
                if (bus.fall_o[i]) obs_q.push_back('{32'(cyc), 8'(i), 1'b0});
            end
        end
    end

    task automatic test_reset();
        logic bad;
        bus.cio_gpio_i  = '0;
        bus.filter_en_i = '0;
`ifdef GPIO_IN_FILTER_GLITCH_CNT_EN
        bus.glitch_clr_i = 1'b0;
`endif
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({bus.data_in_o, bus.rise_o, bus.fall_o} !== '0) begin
            failures++;
            $display("FAIL reset_hold got data=%h rise=%h fall=%h want 0", bus.data_in_o, bus.rise_o, bus.fall_o);
        end
        rst_ni = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk_i);
            if ((bus.data_in_o | bus.rise_o | bus.fall_o) !== '0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_release got activity=1 want 0");
        end
    endtask

    task automatic test_unfiltered();
        int  c;
        ev_t e, o;
        @(negedge clk_i);
        c = cyc;
        bus.cio_gpio_i[5] = 1'b1;
        exp_q.push_back('{32'(c + 3), 8'd5, 1'b1});
        repeat (2) @(negedge clk_i);
        checks++;
        if (bus.data_in_o[5] !== 1'b0) begin
            failures++;
            $display("FAIL unfilt_early got %b want 0", bus.data_in_o[5]);
        end
        @(negedge clk_i);
        checks++;
        if (bus.data_in_o[5] !== 1'b1) begin
            failures++;
            $display("FAIL unfilt_lat3 got %b want 1", bus.data_in_o[5]);
        end
        @(negedge clk_i);
        bus.cio_gpio_i[5] = 1'b0;
        exp_q.push_back('{32'(cyc + 3), 8'd5, 1'b0});
        repeat (8) @(negedge clk_i);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL unfilt_evt got cyc=%0d lane=%0d rise=%0b want cyc=%0d lane=%0d rise=%0b", o.cyc, o.lane, o.rise, e.cyc, e.lane, e.rise);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL unfilt_extra got %0d stray events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_filter_reject();
        int   c, hi;
        logic seen;
        ev_t  e, o;
        bus.filter_en_i = '1;
        repeat (25) @(negedge clk_i);
        @(negedge clk_i);
        bus.cio_gpio_i[0] = 1'b1;
        repeat (16) @(negedge clk_i);
        bus.cio_gpio_i[0] = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (bus.data_in_o[0]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reject16 got data_in[0] high=1 want 0");
        end
        @(negedge clk_i);
        c = cyc;
        bus.cio_gpio_i[0] = 1'b1;
        exp_q.push_back('{32'(c + 20), 8'd0, 1'b1});
        repeat (17) @(negedge clk_i);
        bus.cio_gpio_i[0] = 1'b0;
        exp_q.push_back('{32'(c + 37), 8'd0, 1'b0});
        hi = 0;
        repeat (45) begin
            @(negedge clk_i);
            if (bus.data_in_o[0]) hi++;
        end
        checks++;
        if (hi != 17) begin
            failures++;
            $display("FAIL accept17_width got %0d cycles want 17", hi);
        end
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL accept17_evt got cyc=%0d lane=%0d rise=%0b want cyc=%0d lane=%0d rise=%0b", o.cyc, o.lane, o.rise, e.cyc, e.lane, e.rise);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL reject_extra got %0d stray events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_step_latency();
        int  c;
        ev_t e, o;
        @(negedge clk_i);
        c = cyc;
        bus.cio_gpio_i[31] = 1'b1;
        exp_q.push_back('{32'(c + 20), 8'd31, 1'b1});
        repeat (19) @(negedge clk_i);
        checks++;
        if (bus.data_in_o[31] !== 1'b0) begin
            failures++;
            $display("FAIL step_early got %b want 0", bus.data_in_o[31]);
        end
        @(negedge clk_i);
        checks++;
        if (bus.data_in_o[31] !== 1'b1) begin
            failures++;
            $display("FAIL step_lat20 got %b want 1", bus.data_in_o[31]);
        end
        @(negedge clk_i);
        checks++;
        if (bus.rise_o[31] !== 1'b0) begin
            failures++;
            $display("FAIL step_pulse_width got rise=%b want 0", bus.rise_o[31]);
        end
        repeat (3) @(negedge clk_i);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL step_evt got cyc=%0d lane=%0d rise=%0b want cyc=%0d lane=%0d rise=%0b", o.cyc, o.lane, o.rise, e.cyc, e.lane, e.rise);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL step_extra got %0d stray events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_enable_toggle();
        logic pad_hist [100];
        logic pad, exp_lvl, last_lvl;
        int   nbad, first_bad;
        ev_t  e, o;
        last_lvl  = 1'b0;
        nbad      = 0;
        first_bad = -1;
        for (int r = 0; r < 100; r++) begin
            @(negedge clk_i);
            exp_lvl = (r >= 23) ? pad_hist[r-3] : 1'b0;
            if (bus.data_in_o[3] !== exp_lvl) begin
                nbad++;
                if (first_bad < 0) first_bad = r;
            end
            if (exp_lvl != last_lvl) exp_q.push_back('{32'(cyc), 8'd3, exp_lvl});
            last_lvl = exp_lvl;
            pad = (r < 40) ? (((r / 4) % 2) == 0) : 1'b1;
            pad_hist[r] = pad;
            bus.cio_gpio_i[3] = pad;
            if (r == 22) bus.filter_en_i[3] = 1'b0;
            if (r == 60) bus.filter_en_i[3] = 1'b1;
        end
        checks++;
        if (nbad != 0) begin
            failures++;
            $display("FAIL toggle_track got %0d bad cycles (first rel %0d) want 0", nbad, first_bad);
        end
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL toggle_evt got cyc=%0d lane=%0d rise=%0b want cyc=%0d lane=%0d rise=%0b", o.cyc, o.lane, o.rise, e.cyc, e.lane, e.rise);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL toggle_extra got %0d stray events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_count();
        int  r;
        ev_t e, o;
        @(negedge clk_i);
        bus.cio_gpio_i[7] = 1'b1;
        repeat (13) @(negedge clk_i);
        checks++;
        if (bus.data_in_o !== 32'h8000_0008) begin
            failures++;
            $display("FAIL midcnt_pre got %h want 80000008", bus.data_in_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({bus.data_in_o, bus.rise_o, bus.fall_o} !== '0) begin
            failures++;
            $display("FAIL midcnt_async got data=%h rise=%h fall=%h want 0", bus.data_in_o, bus.rise_o, bus.fall_o);
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        r = cyc;
        exp_q.push_back('{32'(r + 20), 8'd3,  1'b1});
        exp_q.push_back('{32'(r + 20), 8'd7,  1'b1});
        exp_q.push_back('{32'(r + 20), 8'd31, 1'b1});
        repeat (19) @(negedge clk_i);
        checks++;
        if (bus.data_in_o !== 32'h0) begin
            failures++;
            $display("FAIL midcnt_early got %h want 0", bus.data_in_o);
        end
        @(negedge clk_i);
        checks++;
        if (bus.data_in_o !== 32'h8000_0088) begin
            failures++;
            $display("FAIL midcnt_lat20 got %h want 80000088", bus.data_in_o);
        end
        repeat (3) @(negedge clk_i);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL midcnt_evt got cyc=%0d lane=%0d rise=%0b want cyc=%0d lane=%0d rise=%0b", o.cyc, o.lane, o.rise, e.cyc, e.lane, e.rise);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL midcnt_extra got %0d stray events want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

`ifdef GPIO_IN_FILTER_GLITCH_CNT_EN
    task automatic test_glitch_cnt();
        @(negedge clk_i);
        bus.glitch_clr_i = 1'b1;
        @(negedge clk_i);
        bus.glitch_clr_i = 1'b0;
        checks++;
        if (bus.glitch_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL glitch_clr0 got %0d want 0", bus.glitch_cnt_o);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            bus.cio_gpio_i[1] = 1'b1;
            repeat (2) @(negedge clk_i);
            bus.cio_gpio_i[1] = 1'b0;
            repeat (30) @(negedge clk_i);
        end
        checks++;
        if (bus.glitch_cnt_o !== 16'd3) begin
            failures++;
            $display("FAIL glitch_three got %0d want 3", bus.glitch_cnt_o);
        end
        checks++;
        if (bus.data_in_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL glitch_level got %b want 0", bus.data_in_o[1]);
        end
        bus.glitch_clr_i = 1'b1;
        @(negedge clk_i);
        bus.glitch_clr_i = 1'b0;
        checks++;
        if (bus.glitch_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL glitch_clr got %0d want 0", bus.glitch_cnt_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_unfiltered();
        test_filter_reject();
        test_step_latency();
        test_enable_toggle();
        test_reset_mid_count();
`ifdef GPIO_IN_FILTER_GLITCH_CNT_EN
        test_glitch_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
